// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Holds the FSM state encoding, the owner tag encoding and the data width.
package imem_arb_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating starvation counter for the fetch requester.
// force_if asserts once fetch has lost STARVE_LIMIT consecutive arbitrations.
module imem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic force_if
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!if_req || if_gnt) begin
      cnt_q <= '0;
    end else if (d_gnt && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign force_if = (cnt_q == LIMIT);

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port 16-bit memory, one registered access per cycle.
// Optional misalignment checking is enabled by defining IMEM_ARB_ALIGN_CHECK_EN.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     mem_data_out,
  output logic                  err_misalign
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  owner_t                  owner_q;
  logic                    force_if;
  logic                    any_gnt;
  logic                    sel_wr;
  logic                    suppress;
  logic                    issue;
  logic                    rd_done;
  logic [ADDR_WIDTH-1:0]   sel_addr;

  imem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt),
    .force_if (force_if)
  );

  // Grants are masked during reset so every output reads 0 while rst_n is low.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (if_req && (!d_req || force_if)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  assign any_gnt  = if_gnt | d_gnt;
  assign sel_addr = d_gnt ? d_addr : if_addr;
  assign sel_wr   = d_gnt & d_wr;
  assign issue    = any_gnt & ~suppress;
  assign state_d  = any_gnt ? ACCESS : IDLE;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  logic misalign;
  logic err_q;

  assign misalign = any_gnt & sel_addr[0];
  assign suppress = misalign & sel_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (misalign) begin
      err_q <= 1'b1;
    end
  end

  assign err_misalign = err_q;
`else
  assign suppress     = 1'b0;
  assign err_misalign = 1'b0;
`endif

  // A completed read is an enabled, non-write access sitting in the memory registers.
  assign rd_done = (state_q == ACCESS) & mem_enable & ~mem_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      if_rvalid   <= 1'b0;
      d_rvalid    <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      state_q    <= state_d;
      mem_enable <= issue;
      mem_wr     <= issue & sel_wr;
      if (any_gnt) begin
        mem_addr <= sel_addr & ALIGN_MASK;
        owner_q  <= d_gnt ? OWN_D : OWN_IF;
      end
      if (sel_wr) begin
        mem_data_in <= d_wdata;
      end
      if_rvalid <= rd_done & (owner_q == OWN_IF);
      d_rvalid  <= rd_done & (owner_q == OWN_D);
      if (rd_done && (owner_q == OWN_IF)) begin
        if_rdata <= mem_data_out;
      end
      if (rd_done && (owner_q == OWN_D)) begin
        d_rdata <= mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: directed stimulus pushes expected reads,
// a negedge monitor pops and compares whenever an rvalid pulses.
module tb_imem_port_arbiter;
  import imem_arb_pkg::*;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [15:0]   if_rdata;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [15:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [15:0]   d_rdata;
  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data_in;
  logic [15:0]   mem_data_out;
  logic          err_misalign;

  typedef struct packed {
    logic        own_d;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] mem [0:255];

  imem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_wr         (d_wr),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_enable   (mem_enable),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write at the rising edge.
  assign mem_data_out = mem[mem_addr[8:1]];
  always @(posedge clk) begin
    if (mem_enable && mem_wr) mem[mem_addr[8:1]] <= mem_data_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_read(input logic own_d, input logic [15:0] data);
    sb_q.push_back('{own_d: own_d, data: data});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (if_rvalid || d_rvalid) begin
      check("rvalid_exclusive", {31'd0, if_rvalid & d_rvalid}, 32'd0);
      if (sb_q.size() == 0) begin
        check("rvalid_unexpected", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rvalid_owner", {31'd0, d_rvalid}, {31'd0, e.own_d});
        check("rdata", {16'd0, (d_rvalid ? d_rdata : if_rdata)}, {16'd0, e.data});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnts"}, {30'd0, if_gnt, d_gnt}, 32'd0);
    check({tag, "_rvalids"}, {30'd0, if_rvalid, d_rvalid}, 32'd0);
    check({tag, "_mem_ctl"}, {30'd0, mem_enable, mem_wr}, 32'd0);
    check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    check({tag, "_mem_din"}, {16'd0, mem_data_in}, 32'd0);
    check({tag, "_rdata"}, {if_rdata, d_rdata}, 32'd0);
    check({tag, "_err"}, {31'd0, err_misalign}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
    mem[2]  = 16'hA5A5;
    mem[8]  = 16'h0BEE;
    mem[32] = 16'h4040;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    next_cycle();

    // Fetch-only read of 0x0004.
    if_req = 1'b1; if_addr = 16'h0004;
    @(negedge clk);
    check("fetch_gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
    expect_read(1'b0, 16'hA5A5);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("fetch_mem_ctl", {30'd0, mem_enable, mem_wr}, 32'd2);
    check("fetch_mem_addr", {16'd0, mem_addr}, 32'h0004);
    next_cycle();
    @(negedge clk);
    check("fetch_rvalid_c2", {30'd0, if_rvalid, d_rvalid}, 32'd2);
    next_cycle();
    @(negedge clk);
    check("idle_mem_enable", {31'd0, mem_enable}, 32'd0);
    next_cycle();

    // Contention: data wins 4 times, fetch forced in cycle 4, data again in cycle 5.
    if_req = 1'b1; if_addr = 16'h0040;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check($sformatf("contend_gnt_%0d", k), {30'd0, if_gnt, d_gnt}, 32'd2);
        expect_read(1'b0, 16'h4040);
      end else begin
        check($sformatf("contend_gnt_%0d", k), {30'd0, if_gnt, d_gnt}, 32'd1);
        expect_read(1'b1, 16'h0BEE);
      end
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) next_cycle();

    // Data write 0x0020 <- 0x1234, then fetch of the same address.
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    @(negedge clk);
    check("wr_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
    next_cycle();
    d_req = 1'b0; d_wr = 1'b0;
    if_req = 1'b1; if_addr = 16'h0020;
    @(negedge clk);
    check("wr_mem_ctl", {30'd0, mem_enable, mem_wr}, 32'd3);
    check("wr_mem_addr", {16'd0, mem_addr}, 32'h0020);
    check("wr_mem_din", {16'd0, mem_data_in}, 32'h1234);
    check("rd_after_wr_gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
    expect_read(1'b0, 16'h1234);
    next_cycle();
    if_req = 1'b0;
    repeat (3) next_cycle();

    // Misaligned data write to 0x0031.
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0031; d_wdata = 16'h5555;
    @(negedge clk);
    check("mis_wr_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
    next_cycle();
    d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    check("mis_wr_suppressed", {31'd0, mem_enable}, 32'd0);
    check("mis_err", {31'd0, err_misalign}, 32'd1);
`else
    check("mis_wr_mem_ctl", {30'd0, mem_enable, mem_wr}, 32'd3);
    check("mis_wr_mem_addr", {16'd0, mem_addr}, 32'h0030);
    check("mis_err", {31'd0, err_misalign}, 32'd0);
`endif
    next_cycle();

    // Read back 0x0030, then a misaligned fetch of 0x0005 (issued aligned to 0x0004).
    d_req = 1'b1; d_addr = 16'h0030;
    @(negedge clk);
    check("readback_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    expect_read(1'b1, 16'hC018);
`else
    expect_read(1'b1, 16'h5555);
`endif
    next_cycle();
    d_req = 1'b0;
    if_req = 1'b1; if_addr = 16'h0005;
    @(negedge clk);
    check("mis_rd_gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
    expect_read(1'b0, 16'hA5A5);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("mis_rd_mem_addr", {16'd0, mem_addr}, 32'h0004);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    check("err_sticky", {31'd0, err_misalign}, 32'd1);
`else
    check("err_tied", {31'd0, err_misalign}, 32'd0);
`endif
    repeat (3) next_cycle();

    // Reset during the access cycle of a granted data read: no rvalid may follow.
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
    @(negedge clk);
    check("rst_rd_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) begin
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    next_cycle();
    d_req = 1'b0;
    rst_n = 1'b1;
    repeat (3) next_cycle();

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
